// File: rtl/rx_frame_writer.sv
// Writes MAC rx frames into the frame buffer behind a length header and publishes the commit pointer
// once a whole good frame has landed. Optional per-frame statistics via RX_FRAME_STATS_EN.
module rx_frame_writer #(
  parameter int ADDR_W        = 10,
  parameter int MAX_FRAME_QWS = 192
) (
  input  logic              clk156,
  input  logic              reset,
  input  logic [63:0]       rx_tdata,
  input  logic [7:0]        rx_tkeep,
  input  logic              rx_tvalid,
  input  logic              rx_tlast,
  input  logic              rx_tuser,
  input  logic [ADDR_W-1:0] commited_rd_address,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [63:0]       buf_wr_data,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] commited_wr_address,
  output logic [31:0]       dropped_frames
`ifdef RX_FRAME_STATS_EN
  ,
  output logic [31:0]       good_frames,
  output logic [31:0]       bad_frames
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_HDR  = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam int QW_W = $clog2(MAX_FRAME_QWS + 1);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_q;
  logic [ADDR_W-1:0] fstart_q, fstart_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [15:0]       byte_cnt_q, byte_cnt_d;
  logic [QW_W-1:0]   qw_cnt_q, qw_cnt_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [63:0]       wd_q, wd_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] commit_q, commit_d;
  logic [31:0]       drop_q, drop_d;
  logic              acc, drop_inc;
  logic [15:0]       kcnt;

  // One slot is always kept free so a full buffer never looks empty.
  function automatic logic blocked(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] rd);
    return (a + ONE) == rd;
  endfunction

  assign kcnt = 16'($countones(rx_tkeep));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    fstart_d   = fstart_q;
    cur_d      = cur_q;
    byte_cnt_d = byte_cnt_q;
    qw_cnt_d   = qw_cnt_q;
    wa_d       = wa_q;
    wd_d       = wd_q;
    we_d       = 1'b0;
    commit_d   = commit_q;
    acc        = 1'b0;
    drop_inc   = 1'b0;
    case (state_q)
      S_IDLE: if (rx_tvalid) begin
        if (blocked(wr_ptr_q + ONE, rd_q) || blocked(wr_ptr_q + TWO, rd_q)) begin
          drop_inc = 1'b1;
          if (!rx_tlast) state_d = S_DROP;
        end else begin
          acc        = 1'b1;
          we_d       = 1'b1;
          wa_d       = wr_ptr_q + ONE;
          wd_d       = rx_tdata;
          fstart_d   = wr_ptr_q;
          cur_d      = wr_ptr_q + TWO;
          byte_cnt_d = kcnt;
          qw_cnt_d   = QW_W'(1);
          state_d    = S_DATA;
        end
      end
      S_DATA: if (rx_tvalid) begin
        if (blocked(cur_q, rd_q) || qw_cnt_q == QW_W'(MAX_FRAME_QWS)) begin
          drop_inc = 1'b1;
          cur_d    = fstart_q;
          state_d  = rx_tlast ? S_IDLE : S_DROP;
        end else begin
          acc        = 1'b1;
          we_d       = 1'b1;
          wa_d       = cur_q;
          wd_d       = rx_tdata;
          cur_d      = cur_q + ONE;
          byte_cnt_d = byte_cnt_q + kcnt;
          qw_cnt_d   = qw_cnt_q + QW_W'(1);
        end
      end
      S_HDR: begin
        we_d     = 1'b1;
        wa_d     = fstart_q;
        wd_d     = {48'b0, byte_cnt_q};
        wr_ptr_d = cur_q;
        commit_d = cur_q;
        state_d  = S_IDLE;
        // A frame starting with no inter-frame gap cannot be headed in time.
        if (rx_tvalid) begin
          drop_inc = 1'b1;
          if (!rx_tlast) state_d = S_DROP;
        end
      end
      default: if (rx_tvalid && rx_tlast) state_d = S_IDLE;
    endcase
    if (acc && rx_tlast) begin
      if (rx_tuser) state_d = S_HDR;
      else begin
        cur_d   = fstart_d;
        state_d = S_IDLE;
      end
    end
    drop_d = (drop_inc && drop_q != '1) ? drop_q + 32'd1 : drop_q;
  end

  always_ff @(posedge clk156) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_q       <= '0;
      fstart_q   <= '0;
      cur_q      <= '0;
      byte_cnt_q <= '0;
      qw_cnt_q   <= '0;
      wa_q       <= '0;
      wd_q       <= '0;
      we_q       <= 1'b0;
      commit_q   <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_q       <= commited_rd_address;
      fstart_q   <= fstart_d;
      cur_q      <= cur_d;
      byte_cnt_q <= byte_cnt_d;
      qw_cnt_q   <= qw_cnt_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      we_q       <= we_d;
      commit_q   <= commit_d;
      drop_q     <= drop_d;
    end
  end

  assign buf_wr_addr         = wa_q;
  assign buf_wr_data         = wd_q;
  assign buf_wr_en           = we_q;
  assign commited_wr_address = commit_q;
  assign dropped_frames      = drop_q;

`ifdef RX_FRAME_STATS_EN
  logic [31:0] good_q, bad_q;

  always_ff @(posedge clk156) begin
    if (reset) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      if (state_q == S_HDR && good_q != '1) good_q <= good_q + 32'd1;
      if (acc && rx_tlast && !rx_tuser && bad_q != '1) bad_q <= bad_q + 32'd1;
    end
  end

  assign good_frames = good_q;
  assign bad_frames  = bad_q;
`endif

endmodule

// File: tb/tb_rx_frame_writer.sv
// Directed bench for rx_frame_writer: expected buffer writes are queued as beats are driven and
// popped by a write monitor; commit pointer and drop counter are checked at each step.
module tb_rx_frame_writer;

  logic        clk156 = 1'b0;
  logic        reset;
  logic [63:0] rx_tdata;
  logic [7:0]  rx_tkeep;
  logic        rx_tvalid, rx_tlast, rx_tuser;
  logic [9:0]  commited_rd_address;
  logic [9:0]  buf_wr_addr;
  logic [63:0] buf_wr_data;
  logic        buf_wr_en;
  logic [9:0]  commited_wr_address;
  logic [31:0] dropped_frames;
`ifdef RX_FRAME_STATS_EN
  logic [31:0] good_frames, bad_frames;
`endif

  rx_frame_writer #(.ADDR_W(10), .MAX_FRAME_QWS(192)) dut (
    .clk156(clk156), .reset(reset),
    .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep), .rx_tvalid(rx_tvalid),
    .rx_tlast(rx_tlast), .rx_tuser(rx_tuser),
    .commited_rd_address(commited_rd_address),
    .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data), .buf_wr_en(buf_wr_en),
    .commited_wr_address(commited_wr_address), .dropped_frames(dropped_frames)
`ifdef RX_FRAME_STATS_EN
    , .good_frames(good_frames), .bad_frames(bad_frames)
`endif
  );

  always #5 clk156 = ~clk156;

  typedef struct packed {
    logic [9:0]  a;
    logic [63:0] d;
  } wr_t;

  wr_t         exp_q[$];
  int          nchecks = 0;
  int          nerr = 0;
  logic [15:0] fid = 16'd0;
  int          commit_exp = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk156) begin
    wr_t e;
    if (!reset && buf_wr_en) begin
      nchecks++;
      assert (exp_q.size() != 0) else begin
        nerr++;
        $error("FAIL wr_unexpected: got addr %0d data %0h exp no write", buf_wr_addr, buf_wr_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        nchecks++;
        assert (buf_wr_addr === e.a) else begin
          nerr++;
          $error("FAIL wr_addr: got %0d exp %0d", buf_wr_addr, e.a);
        end
        nchecks++;
        assert (buf_wr_data === e.d) else begin
          nerr++;
          $error("FAIL wr_data@%0d: got %0h exp %0h", e.a, buf_wr_data, e.d);
        end
      end
    end
  end

  // n beats; first nwr are expected in the buffer from start+1; header at start when hdr.
  task automatic send_frame(input int n, input logic [7:0] lkeep, input bit user, input int start,
                            input int nwr, input bit hdr, input bit idle_after, input int exp_commit);
    logic [15:0] bytes;
    logic [63:0] d;
    wr_t         w;
    fid++;
    bytes = 16'd0;
    for (int i = 0; i < n; i++) begin
      d         = {16'hA5A5, fid, 32'(i)};
      rx_tdata  = d;
      rx_tkeep  = (i == n - 1) ? lkeep : 8'hFF;
      rx_tlast  = (i == n - 1);
      rx_tuser  = (i == n - 1) ? user : 1'b0;
      rx_tvalid = 1'b1;
      bytes     = bytes + 16'($countones(rx_tkeep));
      if (i < nwr) begin
        w.a = 10'((start + 1 + i) % 1024);
        w.d = d;
        exp_q.push_back(w);
      end
      @(negedge clk156);
    end
    if (hdr) begin
      w.a = 10'(start);
      w.d = {48'b0, bytes};
      exp_q.push_back(w);
    end
    if (idle_after) begin
      rx_tvalid = 1'b0;
      rx_tlast  = 1'b0;
      rx_tuser  = 1'b0;
      check("commit_before_hdr", 64'(commited_wr_address), 64'(commit_exp));
      @(negedge clk156);
      check("commit_after_hdr", 64'(commited_wr_address), 64'(exp_commit));
      commit_exp = exp_commit;
      repeat (2) @(negedge clk156);
      check("writes_drained", 64'(exp_q.size()), 64'd0);
    end
  endtask

  initial begin
    wr_t w;
    reset = 1'b1;
    rx_tdata = '0; rx_tkeep = '0; rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0;
    commited_rd_address = '0;
    repeat (3) @(negedge clk156);
    check("rst_wr_en", 64'(buf_wr_en), 64'd0);
    check("rst_wr_addr", 64'(buf_wr_addr), 64'd0);
    check("rst_wr_data", buf_wr_data, 64'd0);
    check("rst_commit", 64'(commited_wr_address), 64'd0);
    check("rst_dropped", 64'(dropped_frames), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk156);

    // full-keep frame, partial last beat, then bad frame rewound under a good one
    send_frame(8, 8'hFF, 1'b1, 0, 8, 1'b1, 1'b1, 9);
    send_frame(8, 8'h1F, 1'b1, 9, 8, 1'b1, 1'b1, 18);
    send_frame(3, 8'hFF, 1'b0, 18, 3, 1'b0, 1'b1, 18);
    send_frame(2, 8'hFF, 1'b1, 18, 2, 1'b1, 1'b1, 21);
    check("dropped_after_bad", 64'(dropped_frames), 64'd0);

    // advance write pointer to 1000 with max-size frames (192 beats is still legal)
    for (int k = 0; k < 5; k++)
      send_frame(192, 8'hFF, 1'b1, 21 + 193 * k, 192, 1'b1, 1'b1, 21 + 193 * (k + 1));
    send_frame(13, 8'hFF, 1'b1, 986, 13, 1'b1, 1'b1, 1000);

    // overflow against rd=0: beats 1..22 land, beat 23 drops the frame
    send_frame(40, 8'hFF, 1'b1, 1000, 22, 1'b0, 1'b1, 1000);
    check("dropped_overflow", 64'(dropped_frames), 64'd1);

    // wrap: bring wr_ptr to 1020 with the reader keeping up, then straddle 1023->0
    commited_rd_address = 10'd1000;
    repeat (2) @(negedge clk156);
    send_frame(19, 8'hFF, 1'b1, 1000, 19, 1'b1, 1'b1, 1020);
    commited_rd_address = 10'd1020;
    repeat (2) @(negedge clk156);
    send_frame(8, 8'hFF, 1'b1, 1020, 8, 1'b1, 1'b1, 5);

    // oversize frame
    commited_rd_address = 10'd5;
    repeat (2) @(negedge clk156);
    send_frame(200, 8'hFF, 1'b1, 5, 192, 1'b0, 1'b1, 5);
    check("dropped_oversize", 64'(dropped_frames), 64'd2);

    // frame arriving in the header cycle is dropped; the prior frame still commits
    send_frame(8, 8'hFF, 1'b1, 5, 8, 1'b1, 1'b0, 14);
    commit_exp = 14;
    send_frame(3, 8'hFF, 1'b1, 0, 0, 1'b0, 1'b1, 14);
    check("dropped_ifg", 64'(dropped_frames), 64'd3);

    // reset in the middle of a frame
    fid++;
    for (int i = 0; i < 4; i++) begin
      rx_tdata  = {16'h5A5A, fid, 32'(i)};
      rx_tkeep  = 8'hFF;
      rx_tlast  = 1'b0;
      rx_tuser  = 1'b0;
      rx_tvalid = 1'b1;
      w.a = 10'(15 + i);
      w.d = rx_tdata;
      exp_q.push_back(w);
      @(negedge clk156);
    end
    #1;
    reset = 1'b1;
    rx_tvalid = 1'b0;
    commited_rd_address = '0;
    @(negedge clk156);
    check("midrst_commit", 64'(commited_wr_address), 64'd0);
    check("midrst_dropped", 64'(dropped_frames), 64'd0);
    check("midrst_wr_en", 64'(buf_wr_en), 64'd0);
    check("midrst_drained", 64'(exp_q.size()), 64'd0);
    reset = 1'b0;
    commit_exp = 0;
    @(negedge clk156);
    send_frame(2, 8'h03, 1'b1, 0, 2, 1'b1, 1'b1, 3);
    check("dropped_final", 64'(dropped_frames), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
